// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC parallel-port bus engine and its command decoders.
package rtc_bus_ctrl_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_A_SETUP  = 3'd1;
  localparam logic [2:0] S_A_STROBE = 3'd2;
  localparam logic [2:0] S_A_HOLD   = 3'd3;
  localparam logic [2:0] S_D_SETUP  = 3'd4;
  localparam logic [2:0] S_D_STROBE = 3'd5;
  localparam logic [2:0] S_D_HOLD   = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic AD_ADDR = 1'b0;
  localparam logic AD_DATA = 1'b1;

  localparam int unsigned DEF_T_SETUP = 2;
  localparam int unsigned DEF_T_LOW   = 10;
  localparam int unsigned DEF_T_HIGH  = 10;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase down-counter: loads duration-1 on state entry, expired when it reaches zero.
module rtc_phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] duration,
  output logic         expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= duration - W'(1);
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Bus engine: one request becomes a multiplexed address/data cycle on the RTC parallel port.
module rtc_bus_ctrl
  import rtc_bus_ctrl_pkg::*;
#(
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_LOW   = DEF_T_LOW,
  parameter int unsigned T_HIGH  = DEF_T_HIGH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ad_sel,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int unsigned CW = $clog2(max3(T_SETUP, T_LOW, T_HIGH) + 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic          w_load;
  logic          w_expired;
  logic [CW-1:0] w_dur;
  logic          w_addr_ph;
  logic          w_data_ph;

  logic       r_wr;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_busy, r_done, r_ad_sel, r_cs_n, r_wr_n, r_rd_n, r_ad_oe;
  logic [7:0] r_rdata, r_ad_out;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start)     w_next = S_A_SETUP;
      S_A_SETUP:  if (w_expired) w_next = S_A_STROBE;
      S_A_STROBE: if (w_expired) w_next = S_A_HOLD;
      S_A_HOLD:   if (w_expired) w_next = S_D_SETUP;
      S_D_SETUP:  if (w_expired) w_next = S_D_STROBE;
      S_D_STROBE: if (w_expired) w_next = S_D_HOLD;
      S_D_HOLD:   if (w_expired) w_next = S_DONE;
      default:                   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = (w_next != r_state);
    unique case (w_next)
      S_A_SETUP, S_D_SETUP:   w_dur = CW'(T_SETUP);
      S_A_STROBE, S_D_STROBE: w_dur = CW'(T_LOW);
      S_A_HOLD, S_D_HOLD:     w_dur = CW'(T_HIGH);
      default:                w_dur = CW'(1);
    endcase
  end

  rtc_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_load),
    .duration (w_dur),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_wr    <= wr;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
    end
  end

  always_comb begin
    w_addr_ph = (r_state == S_A_SETUP) || (r_state == S_A_STROBE) || (r_state == S_A_HOLD);
    w_data_ph = (r_state == S_D_SETUP) || (r_state == S_D_STROBE) || (r_state == S_D_HOLD);
  end

  // Pins are registered from the current state, so each pin pattern trails its state by one
  // cycle; rdata is captured on the last read strobe cycle while rd_n is still low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_ad_sel <= AD_ADDR;
      r_cs_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_ad_out <= '0;
      r_ad_oe  <= 1'b0;
    end else begin
      r_busy   <= (r_state != S_IDLE);
      r_done   <= (r_state == S_DONE);
      r_ad_sel <= w_data_ph ? AD_DATA : AD_ADDR;
      r_cs_n   <= !((r_state == S_A_STROBE) || (r_state == S_D_STROBE));
      r_wr_n   <= !((r_state == S_A_STROBE) || ((r_state == S_D_STROBE) && r_wr));
      r_rd_n   <= !((r_state == S_D_STROBE) && !r_wr);
      r_ad_oe  <= w_addr_ph || (w_data_ph && r_wr);
      r_ad_out <= w_addr_ph ? r_addr : ((w_data_ph && r_wr) ? r_wdata : '0);
      if (r_state == S_D_STROBE && w_expired && !r_wr) begin
        r_rdata <= ad_in;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign rdata  = r_rdata;
  assign ad_sel = r_ad_sel;
  assign cs_n   = r_cs_n;
  assign wr_n   = r_wr_n;
  assign rd_n   = r_rd_n;
  assign ad_out = r_ad_out;
  assign ad_oe  = r_ad_oe;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: driver queues expected transactions, monitor checks them.
module tb_rtc_bus_ctrl;

  localparam int unsigned LAT = 45;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, wr;
  logic [7:0] addr, wdata;
  logic       busy, done;
  logic [7:0] rdata;
  logic       ad_sel, cs_n, wr_n, rd_n, ad_oe;
  logic [7:0] ad_out, ad_in;
  logic [7:0] rtc_val;

  int unsigned cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int unsigned done_cyc;
  } exp_t;

  exp_t q[$];
  logic [7:0] exp_last_rdata = 8'h00;
  int a_cnt = 0, d_cnt = 0, s_cnt = 0;

  rtc_bus_ctrl #(.T_SETUP(2), .T_LOW(10), .T_HIGH(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ad_sel(ad_sel), .cs_n(cs_n),
    .wr_n(wr_n), .rd_n(rd_n), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC model: drives its register value only while it is being read
  assign ad_in = (!rd_n) ? rtc_val : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("no_rd_wr_overlap", {31'd0, (!rd_n && !wr_n)}, 32'd0);
    chk("no_oe_during_rd", {31'd0, (ad_oe && !rd_n)}, 32'd0);
    if (!reset_n) begin
      a_cnt = 0; d_cnt = 0; s_cnt = 0;
    end else begin
      if (q.size() > 0) begin
        e = q[0];
        if (!cs_n) s_cnt++;
        if (!cs_n && !wr_n && rd_n && ad_sel == 1'b0 && ad_oe && ad_out == e.addr) a_cnt++;
        if (!cs_n && ad_sel == 1'b1) begin
          if (e.wr && !wr_n && rd_n && ad_oe && ad_out == e.wdata) d_cnt++;
          if (!e.wr && !rd_n && wr_n && !ad_oe) d_cnt++;
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("done_latency", cyc, e.done_cyc);
          chk("rdata", {24'd0, rdata}, {24'd0, e.rdata});
          chk("busy_in_done", {31'd0, busy}, 32'd1);
          chk("addr_strobe_cycles", a_cnt, 32'd10);
          chk("data_strobe_cycles", d_cnt, 32'd10);
          chk("total_cs_cycles", s_cnt, 32'd20);
        end
        a_cnt = 0; d_cnt = 0; s_cnt = 0;
      end
    end
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] rv);
    exp_t e;
    @(negedge clk);
    start = 1'b1; wr = w; addr = a; wdata = d; rtc_val = rv;
    if (!w) exp_last_rdata = rv;
    e.wr = w; e.addr = a; e.wdata = d; e.rdata = exp_last_rdata;
    e.done_cyc = cyc + 1 + LAT;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; wr = ~w; addr = ~a; wdata = ~d;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 32'd0);
    q.delete();
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int unsigned k;
    bit found;
    reset_n = 1'b0; start = 1'b0; wr = 1'b0; addr = '0; wdata = '0; rtc_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_ad_sel", {31'd0, ad_sel}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_wr_n", {31'd0, wr_n}, 32'd1);
    chk("rst_rd_n", {31'd0, rd_n}, 32'd1);
    chk("rst_ad_out", {24'd0, ad_out}, 32'd0);
    chk("rst_ad_oe", {31'd0, ad_oe}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    issue(1'b1, 8'h02, 8'h10, 8'h00);
    wait_idle();
    issue(1'b0, 8'h21, 8'h00, 8'hD2);
    wait_idle();

    // start pulsed mid-transaction must be ignored
    issue(1'b1, 8'h02, 8'h10, 8'h00);
    repeat (20) @(negedge clk);
    start = 1'b1; wr = 1'b0; addr = 8'hFF; wdata = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (60) @(negedge clk);

    // back-to-back: start held high through DONE re-issues with the new inputs
    @(negedge clk);
    start = 1'b1; wr = 1'b1; addr = 8'h07; wdata = 8'hA5;
    k = cyc + 1;
    e.wr = 1'b1; e.addr = 8'h07; e.wdata = 8'hA5; e.rdata = exp_last_rdata;
    e.done_cyc = k + LAT;
    q.push_back(e);
    @(negedge clk);
    wr = 1'b0; addr = 8'h3C; wdata = 8'h00; rtc_val = 8'h96;
    exp_last_rdata = 8'h96;
    e.wr = 1'b0; e.addr = 8'h3C; e.wdata = 8'h00; e.rdata = 8'h96;
    e.done_cyc = k + LAT + 1 + LAT;
    q.push_back(e);
    while (cyc < k + LAT + 1) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset during the data strobe releases the bus immediately
    issue(1'b1, 8'h33, 8'h44, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (ad_sel && !wr_n) found = 1'b1;
    end
    chk("reach_d_strobe", {31'd0, found}, 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("midrst_wr_n", {31'd0, wr_n}, 32'd1);
    chk("midrst_rd_n", {31'd0, rd_n}, 32'd1);
    chk("midrst_ad_oe", {31'd0, ad_oe}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    q.delete();
    exp_last_rdata = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_rdata", {24'd0, rdata}, 32'd0);

    issue(1'b0, 8'h0F, 8'h00, 8'h5C);
    wait_idle();
    issue(1'b1, 8'h11, 8'h22, 8'h00);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
